instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream stage of the multicycle control FSM. Owns the PC, fetches 16-bit instructions from
//  instruction memory over a req/ack handshake, and holds them in the IR. Presents op[3:0] and
//  register/immediate fields to the control FSM and datapath, and accepts PC redirects for
//  branches and jumps. A timeout watchdog flags a memory that never acknowledges.
// PARAMETERS
//  ADDR_W   16  PC / instruction-memory address width
//  TIMEOUT  15  max cycles imem_req may stay high without imem_ack; 0 disables the watchdog
// PORTS
//  clock       in   1       system clock, all state updates on posedge
//  start       in   1       reset, synchronous, active-high
//  fetch       in   1       one-cycle request from the FSM: fetch the instruction at the PC
//  pc_load     in   1       redirect: load pc_target into the PC
//  pc_target   in   ADDR_W  branch/jump target from the datapath
//  imem_req    out  1       read request to instruction memory
//  imem_addr   out  ADDR_W  read address; valid while imem_req=1
//  imem_ack    in   1       memory has imem_rdata valid this cycle
//  imem_rdata  in   16      instruction word
//  pc          out  ADDR_W  current PC
//  ir          out  16      instruction register
//  op          out  4       ir[15:12], to the FSM opcode decoder
//  ra,rb,rc    out  4 each  ir[11:8], ir[7:4], ir[3:0]
//  imm8        out  8       ir[7:0]
//  ir_valid    out  1       IR holds a completed fetch not yet superseded
//  busy        out  1       a fetch is in progress (state REQ)
//  fault       out  1       sticky watchdog timeout flag
// BEHAVIOUR
//  Reset (start=1 at a clock edge) forces: pc=0, ir=0 (so op=0), ir_valid=0, imem_req=0,
//   busy=0, fault=0, state=IDLE, pending redirect cleared, watchdog=0. Reset wins over every
//   other input, including mid-fetch; an ack arriving in the reset cycle is discarded.
//  States: IDLE, REQ, ERR. All outputs are registered except op/ra/rb/rc/imm8 (IR slices)
//   and imem_addr (=pc).
//  IDLE: fetch=1 -> REQ, and ir_valid<=0. pc_load=1 -> pc<=pc_target. If both are set in the
//   same cycle, the PC loads pc_target and the fetch uses pc_target.
//  REQ: imem_req=1, busy=1, imem_addr=pc. When imem_ack=1: ir<=imem_rdata, ir_valid<=1,
//   pc<=pc+1 (modulo 2^ADDR_W, so all-ones wraps to 0), next state IDLE.
//   fetch is ignored while in REQ.
//  Latency: fetch at edge N -> imem_req high from cycle N+1. First ack sampled at edge M
//   (M>=N+1) -> ir/ir_valid/pc updated and imem_req low from cycle M+1. Minimum fetch is
//   2 cycles.
//  Redirect during REQ: pc_load is captured into the pending register (the latest value wins).
//   On ack, pc<=pending target instead of pc+1, and pending is cleared. The fetched word is
//   still written into the IR.
//  Watchdog: counts cycles spent in REQ without ack, cleared on entry to REQ. If the count
//   reaches TIMEOUT with no ack -> ERR: imem_req=0, fault=1, ir_valid=0, and pc is held.
//   ERR is exited only by reset; fetch and pc_load are ignored there. An ack in the same cycle
//   as the timeout is honoured and no fault is raised.
//  imem_ack outside REQ is ignored.
// TESTING
//  1 Reset, pc_load target=0x0040, fetch; ack 3 cycles later with 0x8123 -> imem_addr=0x0040,
//    ir=0x8123, op=8, ra=1, rb=2, rc=3, pc=0x0041, ir_valid=1, req low the cycle after ack.
//  2 Same-cycle fetch+pc_load(0x0100) in IDLE -> imem_addr=0x0100 on the first req cycle;
//    zero-wait ack -> fetch completes in 2 cycles.
//  3 pc=0xFFFF, fetch, ack 0x1000 -> pc=0x0000, op=1.
//  4 pc_load 0x0200, then 0x0300 during REQ, then ack -> ir updated, pc=0x0300, not pc+1.
//  5 TIMEOUT=15, fetch, no ack -> imem_req high exactly 15 cycles, then fault=1 and req=0;
//    a later fetch is ignored; start=1 clears fault, pc=0, state IDLE.
//  6 Assert start while in REQ, coincident with ack -> ir=0, ir_valid=0, pc=0, imem_req=0
//    on the next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 16-bit words over a req/ack
// handshake into the IR, accepts redirects, and faults on a silent memory.
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              start,
  input  logic              fetch,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic [3:0]        op,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [3:0]        rc,
  output logic [7:0]        imm8,
  output logic              ir_valid,
  output logic              busy,
  output logic              fault
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

  state_t            state;
  logic [WD_W-1:0]   wdog;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_target;

  assign imem_addr = pc;
  assign op        = ir[15:12];
  assign ra        = ir[11:8];
  assign rb        = ir[7:4];
  assign rc        = ir[3:0];
  assign imm8      = ir[7:0];

  // Pending target is qualified by pend_vld, so it carries no reset.
  always_ff @(posedge clock) begin
    if (start) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      imem_req <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      pend_vld <= 1'b0;
      wdog     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load)
            pc <= pc_target;
          if (fetch) begin
            state    <= REQ;
            ir_valid <= 1'b0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            wdog     <= '0;
            pend_vld <= 1'b0;
          end
        end
        REQ: begin
          if (pc_load) begin
            pend_vld    <= 1'b1;
            pend_target <= pc_target;
          end
          // An ack wins over a coincident timeout.
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            pend_vld <= 1'b0;
            state    <= IDLE;
            if (pc_load)
              pc <= pc_target;
            else if (pend_vld)
              pc <= pend_target;
            else
              pc <= pc + ADDR_W'(1);
          end else if (WD_EN && (wdog == WD_LAST)) begin
            state    <= ERR;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b1;
            ir_valid <= 1'b0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
